nearest_neighbor_read_sched: RTL and testbench
==============================================

// Module: nearest_neighbor_read_sched
// PURPOSE
//  Iteration-domain controller for op_hcompute_nearest_neighbor in the up_sample pipeline.
//  - Walks the 3-level loop nest and drives the read side of hw_input_stencil_ub:
//    ren, plus ctrl_vars[2:0] = {x, y, c}. That buffer returns read data combinationally.
//  - Registers the returned pixel into a 1-entry output stage with valid/ready.
//  - The compute kernel consumes the output stage and writes nearest_neighbor_stencil_ub.
// PARAMETERS
//  X_EXTENT  128  inner loop trip count (ctrl_vars[2]); 1..65535
//  Y_EXTENT  128  middle loop trip count (ctrl_vars[1]); 1..65535
//  C_EXTENT  1    outer loop trip count (ctrl_vars[0]); 1..65535
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      async active-low reset
//  flush      in   1      sync clear to IDLE; higher priority than all other inputs
//  start      in   1      1-cycle pulse; begins a frame when in IDLE
//  busy       out  1      high in RUN and DRAIN
//  done       out  1      1-cycle pulse when the last pixel is accepted downstream
//  rd_ren     out  1      read enable to the input buffer
//  rd_ctrl    out  3x16   ctrl_vars to the input buffer: [0]=c, [1]=y, [2]=x
//  rd_data    in   16     combinational read data from the input buffer
//  out_valid  out  1      output stage holds a pixel
//  out_ready  in   1      downstream accepts the pixel
//  out_data   out  16     pixel
//  out_x      out  16     x coordinate of out_data
//  out_y      out  16     y coordinate of out_data
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; counters c/y/x=0.
//   - rd_ren, out_valid, busy, done = 0; out_data, out_x, out_y = 0.
//  FSM states: IDLE -> RUN on start. RUN -> DRAIN when the last tuple issues.
//   DRAIN -> DONE on the last accept. DONE -> IDLE after one cycle; done=1 only in DONE.
//   start outside IDLE is ignored.
//  Issue (combinational): rd_ren = (state==RUN) && (!out_valid || out_ready).
//   rd_ctrl always equals the current counters {c, y, x}.
//  Capture: on a cycle with rd_ren=1, the next posedge does:
//   - out_data <= rd_data; out_x <= x; out_y <= y; out_valid <= 1.
//   - counters advance.
//  Output-stage clear: out_valid clears on accept (out_valid && out_ready) with no
//   simultaneous issue. Accept and issue in the same cycle refill the stage, so
//   out_valid stays 1.
//  Latency: tuple issued in cycle N -> out_valid in N+1. Throughput is 1 pixel/clk
//   while out_ready=1.
//  Counter order: x increments first; x wraps X_EXTENT-1 -> 0 and carries into y;
//   y wraps Y_EXTENT-1 -> 0 and carries into c.
//   - Issuing (C-1, Y-1, X-1) sets state=DRAIN and resets the counters to 0.
//  Widths: counters are 16-bit unsigned; wrap is compared against EXTENT-1 (no modulo).
//  Backpressure: out_valid=1 && out_ready=0 holds out_data/out_x/out_y, the counters
//   and rd_ctrl stable, with rd_ren=0.
//  Extents of 1: every loop of extent 1 wraps each issue. A 1x1x1 frame goes
//   RUN (1 cycle) -> DRAIN -> DONE.
//  flush (sync): same effect as reset on the next posedge; takes priority over start,
//   issue and accept. Any pixel in the output stage is dropped.
//  Reset mid-frame: immediate return to the reset state; no done pulse.
// CONFIGURATION
//  Macro NN_READ_SCHED_PERF_EN:
//   - Defined: adds output stall_cnt (32 bits) and output frame_cyc (32 bits).
//     stall_cnt counts cycles with out_valid && !out_ready while busy.
//     frame_cyc counts cycles from the start accept up to and including DONE.
//     Both clear on reset, on flush, and on start accepted in IDLE; both saturate at
//     all-ones and hold after DONE.
//   - Undefined: both ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. X=4,Y=2,C=1, start at cycle 0, out_ready=1, rd_data=16*y+x
//     -> rd_ren high cycles 1..8; 8 outputs on consecutive cycles, (x,y) in order
//     (0,0),(1,0)..(3,1), data 0,1,2,3,16,17,18,19; done=1 at cycle 10.
//  2. Same config, out_ready toggling 1,0,1,0 -> no pixel lost or duplicated; while
//     stalled, out_data/rd_ctrl are stable and rd_ren=0; 8 accepts, then one done pulse.
//  3. X=Y=C=1 -> exactly one rd_ren with rd_ctrl={0,0,0}; one output; done 2 cycles
//     after the issue.
//  4. Default 128x128 config, flush at 3rd output with out_valid=1 -> next cycle IDLE,
//     out_valid=0, busy=0, no done; a new start restarts from (0,0).
//  5. rst_n low for 1 cycle mid-frame, plus start pulses while busy -> outputs reset
//     asynchronously; start while busy has no effect on the counters.
//  6. NN_READ_SCHED_PERF_EN defined, scenario 2 -> stall_cnt=number of stalled cycles
//     (4); frame_cyc=total frame cycles, held after done.

Source files
------------

// File: rtl/nearest_neighbor_read_sched.sv
// Read-side scheduler for op_hcompute_nearest_neighbor: walks the {c, y, x} loop nest,
// reads hw_input_stencil_ub combinationally and registers each pixel into a 1-entry
// valid/ready output stage. Latency: issue in cycle N -> out_valid in N+1, 1 pixel/clk.
// Backpressure: a held output stage (out_valid && !out_ready) stalls issue, counters and rd_ctrl.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 sync clear to IDLE, dominates start/issue/accept
//   start                 1-cycle pulse, starts a frame from IDLE
//   busy, done            busy in RUN/DRAIN; done pulses one cycle after the last accept
//   rd_ren, rd_ctrl       read strobe and {x, y, c} ctrl_vars ([2]=x, [1]=y, [0]=c)
//   rd_data               combinational read data from the input buffer
//   out_valid/ready/data  output stage handshake and pixel, with out_x/out_y coordinates
// Optional macro NN_READ_SCHED_PERF_EN adds stall_cnt and frame_cyc performance counters.
module nearest_neighbor_read_sched #(
  parameter int X_EXTENT = 128,
  parameter int Y_EXTENT = 128,
  parameter int C_EXTENT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_ren,
  output logic [2:0][15:0] rd_ctrl,
  input  logic [15:0]      rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [15:0]      out_x,
  output logic [15:0]      out_y
`ifdef NN_READ_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      frame_cyc
`endif
);

  // Wrap points are compared directly; counters never exceed EXTENT-1.
  localparam logic [15:0] X_LAST = 16'(X_EXTENT - 1);
  localparam logic [15:0] Y_LAST = 16'(Y_EXTENT - 1);
  localparam logic [15:0] C_LAST = 16'(C_EXTENT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, y_q, c_q;
  logic        x_wrap, y_wrap, c_wrap, last_tuple, accept;

  assign x_wrap     = (x_q == X_LAST);
  assign y_wrap     = (y_q == Y_LAST);
  assign c_wrap     = (c_q == C_LAST);
  assign last_tuple = x_wrap && y_wrap && c_wrap;
  assign accept     = out_valid && out_ready;

  assign rd_ctrl[0] = c_q;
  assign rd_ctrl[1] = y_q;
  assign rd_ctrl[2] = x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_ren  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Issue whenever the output stage is empty or being emptied this cycle.
        rd_ren = !out_valid || out_ready;
        if (rd_ren && last_tuple) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Nothing issues in DRAIN, so this accept is the final pixel of the frame.
        if (accept) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Loop nest counters: x innermost, carry ripples into y then c. The last
  // tuple wraps all three, leaving the counters at 0 for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else if (flush) begin
      x_q <= '0;
      y_q <= '0;
      c_q <= '0;
    end else if (rd_ren) begin
      if (!x_wrap) begin
        x_q <= x_q + 16'd1;
      end else begin
        x_q <= '0;
        if (!y_wrap) begin
          y_q <= y_q + 16'd1;
        end else begin
          y_q <= '0;
          c_q <= c_wrap ? 16'd0 : c_q + 16'd1;
        end
      end
    end
  end

  // Output stage: an issue always refills it (covers simultaneous accept).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (rd_ren) begin
      out_valid <= 1'b1;
      out_data  <= rd_data;
      out_x     <= x_q;
      out_y     <= y_q;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NN_READ_SCHED_PERF_EN
  // Both counters restart on a frame start and freeze once back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      frame_cyc <= '0;
    end else if (flush || (state_q == IDLE && start)) begin
      stall_cnt <= '0;
      frame_cyc <= '0;
    end else begin
      if (busy && out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (state_q != IDLE && frame_cyc != '1) frame_cyc <= frame_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nearest_neighbor_read_sched.sv
// Directed bench for nearest_neighbor_read_sched: three instances (4x2x1, 128x128x1, 1x1x1),
// inputs driven on the falling edge, outputs sampled 1 time unit later.
// Input buffer model returns 16*y + x for the requested ctrl_vars.
module tb_nearest_neighbor_read_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: X=4, Y=2, C=1
  logic start_a = 1'b0, flush_a = 1'b0, ready_a = 1'b1;
  logic busy_a, done_a, ren_a, ov_a;
  logic [2:0][15:0] ctrl_a;
  logic [15:0] rdd_a, od_a, ox_a, oy_a;
  assign rdd_a = ctrl_a[1] * 16'd16 + ctrl_a[2];

  // Instance B: default 128x128x1
  logic start_b = 1'b0, flush_b = 1'b0, ready_b = 1'b1;
  logic busy_b, done_b, ren_b, ov_b;
  logic [2:0][15:0] ctrl_b;
  logic [15:0] rdd_b, od_b, ox_b, oy_b;
  assign rdd_b = ctrl_b[1] * 16'd16 + ctrl_b[2];

  // Instance C: 1x1x1
  logic start_c = 1'b0, flush_c = 1'b0, ready_c = 1'b1;
  logic busy_c, done_c, ren_c, ov_c;
  logic [2:0][15:0] ctrl_c;
  logic [15:0] rdd_c, od_c, ox_c, oy_c;
  assign rdd_c = ctrl_c[1] * 16'd16 + ctrl_c[2];

`ifdef NN_READ_SCHED_PERF_EN
  logic [31:0] stall_a, frame_a, stall_b, frame_b, stall_c, frame_c;
`endif

  nearest_neighbor_read_sched #(.X_EXTENT(4), .Y_EXTENT(2), .C_EXTENT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_ren(ren_a), .rd_ctrl(ctrl_a), .rd_data(rdd_a), .out_valid(ov_a), .out_ready(ready_a),
    .out_data(od_a), .out_x(ox_a), .out_y(oy_a)
`ifdef NN_READ_SCHED_PERF_EN
    , .stall_cnt(stall_a), .frame_cyc(frame_a)
`endif
  );

  nearest_neighbor_read_sched dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_ren(ren_b), .rd_ctrl(ctrl_b), .rd_data(rdd_b), .out_valid(ov_b), .out_ready(ready_b),
    .out_data(od_b), .out_x(ox_b), .out_y(oy_b)
`ifdef NN_READ_SCHED_PERF_EN
    , .stall_cnt(stall_b), .frame_cyc(frame_b)
`endif
  );

  nearest_neighbor_read_sched #(.X_EXTENT(1), .Y_EXTENT(1), .C_EXTENT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush_c), .start(start_c), .busy(busy_c), .done(done_c),
    .rd_ren(ren_c), .rd_ctrl(ctrl_c), .rd_data(rdd_c), .out_valid(ov_c), .out_ready(ready_c),
    .out_data(od_c), .out_x(ox_c), .out_y(oy_c)
`ifdef NN_READ_SCHED_PERF_EN
    , .stall_cnt(stall_c), .frame_cyc(frame_c)
`endif
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, ren_a, ov_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000", {busy_a, done_a, ren_a, ov_a});
    end
    checks++;
    if ({ctrl_a, od_a, ox_a, oy_a} !== '0) begin
      errors++;
      $display("FAIL reset_data got ctrl=%h data=%h x=%h y=%h required all zero", ctrl_a, od_a, ox_a, oy_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scenario 1: full-rate frame.
  task automatic test_basic();
    logic [3:0] exp_f;
    int k;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      start_a = (t == 0);
      ready_a = 1'b1;
      #1;
      exp_f = {(t >= 1 && t <= 9), (t == 10), (t >= 1 && t <= 8), (t >= 2 && t <= 9)};
      checks++;
      if ({busy_a, done_a, ren_a, ov_a} !== exp_f) begin
        errors++;
        $display("FAIL basic_flags t=%0d got %b required %b", t, {busy_a, done_a, ren_a, ov_a}, exp_f);
      end
      if (t >= 1 && t <= 8) begin
        k = t - 1;
        checks++;
        if (ctrl_a !== {16'(k % 4), 16'(k / 4), 16'd0}) begin
          errors++;
          $display("FAIL basic_ctrl t=%0d got %h required x=%0d y=%0d c=0", t, ctrl_a, k % 4, k / 4);
        end
      end
      if (t >= 2 && t <= 9) begin
        k = t - 2;
        checks++;
        if ({od_a, ox_a, oy_a} !== {16'(16 * (k / 4) + k % 4), 16'(k % 4), 16'(k / 4)}) begin
          errors++;
          $display("FAIL basic_out t=%0d got data=%0d x=%0d y=%0d required data=%0d x=%0d y=%0d",
                   t, od_a, ox_a, oy_a, 16 * (k / 4) + k % 4, k % 4, k / 4);
        end
      end
    end
  endtask

  // Scenario 2: out_ready low on cycles 3,5,7,9 while a pixel is held.
  task automatic test_back_pressure();
    int acc = 0;
    int dones = 0;
    logic prev_stall = 1'b0;
    logic exp_ren;
    logic [15:0] prev_od = '0;
    logic [2:0][15:0] prev_ctrl = '0;
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      start_a = (t == 0);
      ready_a = !(t >= 3 && t <= 9 && (t % 2) == 1);
      #1;
      exp_ren = (t == 1 || t == 2 || t == 4 || t == 6 || t == 8 || t == 10 || t == 11 || t == 12);
      checks++;
      if (ren_a !== exp_ren) begin
        errors++;
        $display("FAIL bp_ren t=%0d got %b required %b", t, ren_a, exp_ren);
      end
      checks++;
      if (done_a !== (t == 14)) begin
        errors++;
        $display("FAIL bp_done t=%0d got %b required %b", t, done_a, (t == 14));
      end
      if (prev_stall) begin
        checks++;
        if (od_a !== prev_od || ctrl_a !== prev_ctrl) begin
          errors++;
          $display("FAIL bp_hold t=%0d got data=%h ctrl=%h required data=%h ctrl=%h",
                   t, od_a, ctrl_a, prev_od, prev_ctrl);
        end
      end
      if (ov_a && ready_a) begin
        checks++;
        if ({od_a, ox_a, oy_a} !== {16'(16 * (acc / 4) + acc % 4), 16'(acc % 4), 16'(acc / 4)}) begin
          errors++;
          $display("FAIL bp_accept idx=%0d got data=%0d x=%0d y=%0d required data=%0d",
                   acc, od_a, ox_a, oy_a, 16 * (acc / 4) + acc % 4);
        end
        acc++;
      end
      if (done_a) dones++;
      prev_stall = ov_a && !ready_a;
      prev_od    = od_a;
      prev_ctrl  = ctrl_a;
    end
    checks++;
    if (acc != 8 || dones != 1) begin
      errors++;
      $display("FAIL bp_counts got accepts=%0d dones=%0d required accepts=8 dones=1", acc, dones);
    end
    ready_a = 1'b1;
  endtask

  // Scenario 3: single-tuple frame.
  task automatic test_unit_extent();
    int rens = 0;
    logic [3:0] exp_f;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      start_c = (t == 0);
      #1;
      exp_f = {(t == 1 || t == 2), (t == 3), (t == 1), (t == 2)};
      checks++;
      if ({busy_c, done_c, ren_c, ov_c} !== exp_f) begin
        errors++;
        $display("FAIL unit_flags t=%0d got %b required %b", t, {busy_c, done_c, ren_c, ov_c}, exp_f);
      end
      if (ren_c) begin
        rens++;
        checks++;
        if (ctrl_c !== '0) begin
          errors++;
          $display("FAIL unit_ctrl got %h required 0", ctrl_c);
        end
      end
    end
    checks++;
    if (rens != 1) begin
      errors++;
      $display("FAIL unit_ren_count got %0d required 1", rens);
    end
  endtask

  // Scenario 4: flush with a pixel in the output stage, then restart.
  task automatic test_flush();
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      start_b = (t == 0 || t == 10);
      flush_b = (t == 4 || t == 13);
      #1;
      if (t == 4) begin
        checks++;
        if (ov_b !== 1'b1 || ox_b !== 16'd2) begin
          errors++;
          $display("FAIL flush_pre got valid=%b x=%0d required valid=1 x=2", ov_b, ox_b);
        end
      end
      if (t == 5) begin
        checks++;
        if ({busy_b, done_b, ren_b, ov_b} !== 4'b0000 || {od_b, ox_b, oy_b, ctrl_b} !== '0) begin
          errors++;
          $display("FAIL flush_post got flags=%b data=%h ctrl=%h required all zero",
                   {busy_b, done_b, ren_b, ov_b}, od_b, ctrl_b);
        end
      end
      if (t >= 5 && t <= 9) begin
        checks++;
        if (done_b !== 1'b0 || busy_b !== 1'b0) begin
          errors++;
          $display("FAIL flush_idle t=%0d got done=%b busy=%b required 0 0", t, done_b, busy_b);
        end
      end
      if (t == 11) begin
        checks++;
        if (ren_b !== 1'b1 || ctrl_b !== '0) begin
          errors++;
          $display("FAIL flush_restart_issue got ren=%b ctrl=%h required ren=1 ctrl=0", ren_b, ctrl_b);
        end
      end
      if (t == 12) begin
        checks++;
        if (ov_b !== 1'b1 || {od_b, ox_b, oy_b} !== '0) begin
          errors++;
          $display("FAIL flush_restart_out got valid=%b data=%0d x=%0d y=%0d required 1 0 0 0",
                   ov_b, od_b, ox_b, oy_b);
        end
      end
    end
    flush_b = 1'b0;
  endtask

  // Scenario 5: start while busy is ignored; async reset mid-frame.
  task automatic test_async_reset();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      start_a = (t == 0 || t == 3);
      #1;
      if (t == 4) begin
        checks++;
        if (ren_a !== 1'b1 || ctrl_a !== {16'd3, 16'd0, 16'd0}) begin
          errors++;
          $display("FAIL rst_busy_start got ren=%b ctrl=%h required ren=1 x=3 y=0 c=0", ren_a, ctrl_a);
        end
      end
      if (t == 5) begin
        checks++;
        if (ov_a !== 1'b1 || busy_a !== 1'b1) begin
          errors++;
          $display("FAIL rst_midframe got valid=%b busy=%b required 1 1", ov_a, busy_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, ren_a, ov_a} !== 4'b0000 || {od_a, ox_a, oy_a, ctrl_a} !== '0) begin
          errors++;
          $display("FAIL rst_async got flags=%b data=%h ctrl=%h required all zero",
                   {busy_a, done_a, ren_a, ov_a}, od_a, ctrl_a);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL rst_after t=%0d got done=%b busy=%b required 0 0", t, done_a, busy_a);
      end
    end
  endtask

`ifdef NN_READ_SCHED_PERF_EN
  // Scenario 6: counters over the back-pressured frame (4 stalls, 14 frame cycles).
  task automatic test_perf();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      start_a = (t == 0);
      ready_a = !(t >= 3 && t <= 9 && (t % 2) == 1);
      #1;
      if (t == 16 || t == 19) begin
        checks++;
        if (stall_a !== 32'd4 || frame_a !== 32'd14) begin
          errors++;
          $display("FAIL perf t=%0d got stall=%0d frame=%0d required stall=4 frame=14", t, stall_a, frame_a);
        end
      end
    end
    ready_a = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_unit_extent();
    test_flush();
`ifdef NN_READ_SCHED_PERF_EN
    test_perf();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
